ex_wb_pipe_reg: RTL and testbench

Parametrised EX-to-WB pipeline register for the RISC-V pipeline. It is generalised in data width, register-address width and retiming depth.
- Adds a valid bit, stall (hold), flush (bubble insert), and per-stage forwarding lookup for two source operands.
- Sits between the ALU output and the register-file write port.
- Feeds forwarding data back to the EX-stage operand muxes.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage.sv | 73 +++++++
 rtl/ex_wb_pipe_reg.sv | 127 ++++++++++++
 tb/tb_ex_wb_pipe_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Purpose: shared constants and stage record for the EX->WB pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Default widths used when the pipeline register is not overridden.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;

  // Deepest retiming chain supported between EX and WB.
  localparam int MAX_DEPTH  = 4;

  // One in-flight writeback record at the default widths.
  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [DEF_REG_AW-1:0] reg_num;
    logic [DEF_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// Purpose: one EX->WB stage register holding valid/regwrite/reg_num/data.
// Latency: 1 cycle from d to q.
// Backpressure: hold_i freezes contents; clear_i loads a bubble and wins over hold_i.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   hold_i, clear_i            freeze / bubble-insert controls
//   valid_i..data_i            incoming record
//   valid_o..data_o            registered record
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              hold_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic              regwrite_i,
  input  logic [REG_AW-1:0] reg_num_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              regwrite_o,
  output logic [REG_AW-1:0] reg_num_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] reg_num_q,  reg_num_d;
  logic [DATA_W-1:0] data_q,     data_d;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    reg_num_d  = reg_num_q;
    data_d     = data_q;
    if (clear_i) begin
      // A killed instruction must vanish even while the pipe is held.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      reg_num_d  = '0;
      data_d     = '0;
    end else if (!hold_i) begin
      valid_d    = valid_i;
      regwrite_d = regwrite_i;
      reg_num_d  = reg_num_i;
      data_d     = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      reg_num_q  <= '0;
      data_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      reg_num_q  <= reg_num_d;
      data_q     <= data_d;
    end
  end

  assign valid_o    = valid_q;
  assign regwrite_o = regwrite_q;
  assign reg_num_o  = reg_num_q;
  assign data_o     = data_q;

endmodule

// File: rtl/ex_wb_pipe_reg.sv
// Purpose: DEPTH-stage EX->WB pipeline register with stall, flush and operand forwarding.
// Latency: DEPTH cycles input-to-EX_WB_*; forwarding is combinational from stage state.
// Backpressure: Stall holds every stage; Flush turns stage 0 into a bubble (older stages still obey Stall).
//
// Ports:
//   Clk, Reset                               clock, async active-low reset
//   Stall, Flush                             pipeline controls
//   ID_EX_*, ALUResult                       incoming instruction
//   Rs1_Num, Rs2_Num                         EX-stage source operands for lookup
//   EX_WB_*                                  oldest stage, drives register-file write
//   Fwd1_Hit/Data, Fwd2_Hit/Data             youngest matching in-flight write per operand
module ex_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W             = DEF_DATA_W,
  parameter int REG_AW             = DEF_REG_AW,
  parameter int DEPTH              = 1,
  parameter int ZERO_REG_HARDWIRED = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ID_EX_Valid,
  input  logic              ID_EX_RegWrite,
  input  logic [REG_AW-1:0] ID_EX_Write_Reg_Num,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [REG_AW-1:0] Rs1_Num,
  input  logic [REG_AW-1:0] Rs2_Num,
  output logic              EX_WB_Valid,
  output logic              EX_WB_RegWrite,
  output logic [REG_AW-1:0] EX_WB_Write_Reg_Num,
  output logic [DATA_W-1:0] EX_WB_ALUResult,
  output logic              Fwd1_Hit,
  output logic [DATA_W-1:0] Fwd1_Data,
  output logic              Fwd2_Hit,
  output logic [DATA_W-1:0] Fwd2_Data
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("ex_wb_pipe_reg: DEPTH must be within 1..4");
  end
  if (DATA_W < 1 || REG_AW < 1) begin : g_bad_width
    $error("ex_wb_pipe_reg: DATA_W and REG_AW must be at least 1");
  end

  logic              st_valid [DEPTH];
  logic              st_rw    [DEPTH];
  logic [REG_AW-1:0] st_rn    [DEPTH];
  logic [DATA_W-1:0] st_data  [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              in_valid;
    logic              in_rw;
    logic [REG_AW-1:0] in_rn;
    logic [DATA_W-1:0] in_data;
    logic              clr;

    if (k == 0) begin : g_head
      assign in_valid = ID_EX_Valid;
      // Mask on entry so a bubble can never carry a write enable downstream.
      assign in_rw    = ID_EX_RegWrite & ID_EX_Valid;
      assign in_rn    = ID_EX_Write_Reg_Num;
      assign in_data  = ALUResult;
      assign clr      = Flush;
    end else begin : g_body
      assign in_valid = st_valid[k-1];
      assign in_rw    = st_rw[k-1];
      assign in_rn    = st_rn[k-1];
      assign in_data  = st_data[k-1];
      assign clr      = 1'b0;
    end

    pipe_stage #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_stage (
      .clk_i      (Clk),
      .rst_ni     (Reset),
      .hold_i     (Stall),
      .clear_i    (clr),
      .valid_i    (in_valid),
      .regwrite_i (in_rw),
      .reg_num_i  (in_rn),
      .data_i     (in_data),
      .valid_o    (st_valid[k]),
      .regwrite_o (st_rw[k]),
      .reg_num_o  (st_rn[k]),
      .data_o     (st_data[k])
    );
  end

  assign EX_WB_Valid         = st_valid[DEPTH-1];
  assign EX_WB_RegWrite      = st_valid[DEPTH-1] & st_rw[DEPTH-1];
  assign EX_WB_Write_Reg_Num = st_rn[DEPTH-1];
  assign EX_WB_ALUResult     = st_data[DEPTH-1];

  // Walk oldest to youngest so the youngest qualifying stage overwrites
  // any older match and ends up as the forwarded value.
  always_comb begin
    Fwd1_Hit  = 1'b0;
    Fwd1_Data = '0;
    Fwd2_Hit  = 1'b0;
    Fwd2_Data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (st_valid[k] && st_rw[k] && (st_rn[k] == Rs1_Num)) begin
        Fwd1_Hit  = 1'b1;
        Fwd1_Data = st_data[k];
      end
      if (st_valid[k] && st_rw[k] && (st_rn[k] == Rs2_Num)) begin
        Fwd2_Hit  = 1'b1;
        Fwd2_Data = st_data[k];
      end
    end
    if (ZERO_REG_HARDWIRED != 0) begin
      if (Rs1_Num == '0) begin
        Fwd1_Hit  = 1'b0;
        Fwd1_Data = '0;
      end
      if (Rs2_Num == '0) begin
        Fwd2_Hit  = 1'b0;
        Fwd2_Data = '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_pipe_reg.sv
// Purpose: directed checks of ex_wb_pipe_reg at DEPTH 1, 2, 3 and DEPTH 3 with register 0 hardwired.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ex_wb_pipe_reg;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Stall, Flush, ID_EX_Valid, ID_EX_RegWrite;
  logic [2:0] ID_EX_Write_Reg_Num, Rs1_Num, Rs2_Num;
  logic [7:0] ALUResult;

  // Instance index: 0 = DEPTH1, 1 = DEPTH2, 2 = DEPTH3, 3 = DEPTH3 with register 0 hardwired.
  logic       o_v   [4];
  logic       o_rw  [4];
  logic [2:0] o_rn  [4];
  logic [7:0] o_d   [4];
  logic       o_f1h [4];
  logic [7:0] o_f1d [4];
  logic       o_f2h [4];
  logic [7:0] o_f2d [4];

  localparam int DEP [4] = '{1, 2, 3, 3};

  for (genvar i = 0; i < 4; i++) begin : g_dut
    ex_wb_pipe_reg #(
      .DATA_W             (8),
      .REG_AW             (3),
      .DEPTH              (DEP[i]),
      .ZERO_REG_HARDWIRED ((i == 3) ? 1 : 0)
    ) u_dut (
      .Clk                 (Clk),
      .Reset               (Reset),
      .Stall               (Stall),
      .Flush               (Flush),
      .ID_EX_Valid         (ID_EX_Valid),
      .ID_EX_RegWrite      (ID_EX_RegWrite),
      .ID_EX_Write_Reg_Num (ID_EX_Write_Reg_Num),
      .ALUResult           (ALUResult),
      .Rs1_Num             (Rs1_Num),
      .Rs2_Num             (Rs2_Num),
      .EX_WB_Valid         (o_v[i]),
      .EX_WB_RegWrite      (o_rw[i]),
      .EX_WB_Write_Reg_Num (o_rn[i]),
      .EX_WB_ALUResult     (o_d[i]),
      .Fwd1_Hit            (o_f1h[i]),
      .Fwd1_Data           (o_f1d[i]),
      .Fwd2_Hit            (o_f2h[i]),
      .Fwd2_Data           (o_f2d[i])
    );
  end

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                       input logic [2:0] rn, input logic [7:0] d,
                       input logic [2:0] r1, input logic [2:0] r2);
    Stall               = st;
    Flush               = fl;
    ID_EX_Valid         = v;
    ID_EX_RegWrite      = rw;
    ID_EX_Write_Reg_Num = rn;
    ALUResult           = d;
    Rs1_Num             = r1;
    Rs2_Num             = r2;
  endtask

  // Inputs are driven on the falling edge; one rising edge later the
  // state is checked on the next falling edge.
  typedef struct {
    logic       st, fl, v, rw;
    logic [2:0] rn;
    logic [7:0] d;
    logic [2:0] r1, r2;
    logic       ev, erw;
    logic [2:0] ern;
    logic [7:0] ed;
    logic       e1h;
    logic [7:0] e1d;
    logic       e2h;
    logic [7:0] e2d;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Stream through the DEPTH3 pipe: fill, stall, non-writing and invalid
    // instructions, flush, stall+flush, and a register-0 write.
    vecs[0] = '{1'b0,1'b0,1'b1,1'b1,3'd1,8'h11,3'd1,3'd2, 1'b0,1'b0,3'd0,8'h00, 1'b1,8'h11, 1'b0,8'h00};
    vecs[1] = '{1'b0,1'b0,1'b1,1'b1,3'd2,8'h22,3'd1,3'd2, 1'b0,1'b0,3'd0,8'h00, 1'b1,8'h11, 1'b1,8'h22};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b1,3'd3,8'h33,3'd3,3'd1, 1'b1,1'b1,3'd1,8'h11, 1'b1,8'h33, 1'b1,8'h11};
    vecs[3] = '{1'b1,1'b0,1'b1,1'b1,3'd4,8'h44,3'd2,3'd5, 1'b1,1'b1,3'd1,8'h11, 1'b1,8'h22, 1'b0,8'h00};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0,3'd2,8'h5A,3'd2,3'd3, 1'b1,1'b1,3'd2,8'h22, 1'b1,8'h22, 1'b1,8'h33};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b1,3'd3,8'h77,3'd3,3'd2, 1'b1,1'b1,3'd3,8'h33, 1'b1,8'h33, 1'b0,8'h00};
    vecs[6] = '{1'b0,1'b1,1'b1,1'b1,3'd4,8'h55,3'd4,3'd3, 1'b1,1'b0,3'd2,8'h5A, 1'b0,8'h00, 1'b0,8'h00};
    vecs[7] = '{1'b0,1'b0,1'b1,1'b1,3'd6,8'h66,3'd6,3'd0, 1'b0,1'b0,3'd3,8'h77, 1'b1,8'h66, 1'b0,8'h00};
    vecs[8] = '{1'b1,1'b1,1'b1,1'b1,3'd7,8'h99,3'd6,3'd7, 1'b0,1'b0,3'd3,8'h77, 1'b0,8'h00, 1'b0,8'h00};
    vecs[9] = '{1'b0,1'b0,1'b1,1'b1,3'd0,8'hE1,3'd0,3'd3, 1'b0,1'b0,3'd0,8'h00, 1'b1,8'hE1, 1'b0,8'h00};

    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);

    // Reset state on every instance.
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_valid[%0d]", i), 32'(o_v[i]),  32'd0);
      chk($sformatf("reset_rw[%0d]", i),    32'(o_rw[i]), 32'd0);
      chk($sformatf("reset_data[%0d]", i),  32'(o_d[i]),  32'd0);
      chk($sformatf("reset_fwd1[%0d]", i),  32'(o_f1h[i]), 32'd0);
    end
    @(negedge Clk);
    Reset = 1'b1;

    for (int n = 0; n < 10; n++) begin
      drive(vecs[n].st, vecs[n].fl, vecs[n].v, vecs[n].rw, vecs[n].rn, vecs[n].d, vecs[n].r1, vecs[n].r2);
      @(negedge Clk);
      chk($sformatf("v%0d_valid", n), 32'(o_v[2]),   32'(vecs[n].ev));
      chk($sformatf("v%0d_rw", n),    32'(o_rw[2]),  32'(vecs[n].erw));
      chk($sformatf("v%0d_rn", n),    32'(o_rn[2]),  32'(vecs[n].ern));
      chk($sformatf("v%0d_data", n),  32'(o_d[2]),   32'(vecs[n].ed));
      chk($sformatf("v%0d_f1h", n),   32'(o_f1h[2]), 32'(vecs[n].e1h));
      chk($sformatf("v%0d_f1d", n),   32'(o_f1d[2]), 32'(vecs[n].e1d));
      chk($sformatf("v%0d_f2h", n),   32'(o_f2h[2]), 32'(vecs[n].e2h));
      chk($sformatf("v%0d_f2d", n),   32'(o_f2d[2]), 32'(vecs[n].e2d));
    end

    // Register 0 is in stage 0 of both DEPTH3 pipes; only the hardwired one suppresses it.
    chk("zero_reg_hit", 32'(o_f1h[3]), 32'd0);
    chk("zero_reg_data", 32'(o_f1d[3]), 32'd0);

    // Youngest-wins: stage 2 holds reg2=F0, stage 0 holds reg2=0F.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'hF0, 3'd2, 3'd2);
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'hAA, 3'd2, 3'd2);
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h0F, 3'd2, 3'd2);
    @(negedge Clk);
    chk("prio_out_data", 32'(o_d[2]),   32'hF0);
    chk("prio_f1h",      32'(o_f1h[2]), 32'd1);
    chk("prio_f1d",      32'(o_f1d[2]), 32'h0F);
    chk("prio_f2d",      32'(o_f2d[2]), 32'h0F);
    chk("prio_z_f1d",    32'(o_f1d[3]), 32'h0F);

    // Asynchronous reset between clock edges.
    #2 Reset = 1'b0;
    #1;
    chk("areset_valid", 32'(o_v[2]),   32'd0);
    chk("areset_rw",    32'(o_rw[2]),  32'd0);
    chk("areset_data",  32'(o_d[2]),   32'd0);
    chk("areset_f1h",   32'(o_f1h[2]), 32'd0);
    chk("areset_f2d",   32'(o_f2d[2]), 32'd0);
    chk("areset_d1",    32'(o_d[0]),   32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // DEPTH1 is a plain register; DEPTH2 has not produced it yet.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'hA7, 3'd0, 3'd0);
    @(negedge Clk);
    chk("d1_rw",     32'(o_rw[0]), 32'd1);
    chk("d1_rn",     32'(o_rn[0]), 32'd5);
    chk("d1_data",   32'(o_d[0]),  32'hA7);
    chk("d2_latency", 32'(o_v[1]), 32'd0);

    // DEPTH2 stall: 0x22 in stage 1, 0x11 in stage 0.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h22, 3'd0, 3'd0);
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 3'd0, 3'd0);
    @(negedge Clk);
    chk("stall_pre", 32'(o_d[1]), 32'h22);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'h99, 3'd0, 3'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk($sformatf("stall_hold%0d_data", c),  32'(o_d[1]), 32'h22);
      chk($sformatf("stall_hold%0d_valid", c), 32'(o_v[1]), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    @(negedge Clk);
    chk("stall_rel_data",  32'(o_d[1]), 32'h11);
    chk("stall_rel_valid", 32'(o_v[1]), 32'd1);
    @(negedge Clk);
    chk("stall_nodup_valid", 32'(o_v[1]), 32'd0);

    // DEPTH2 flush: the killed write is never forwarded nor written back.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h55, 3'd4, 3'd0);
    @(negedge Clk);
    chk("flush_f1h", 32'(o_f1h[1]), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd0);
    @(negedge Clk);
    chk("flush_out_rw",   32'(o_rw[1]),  32'd0);
    chk("flush_out_data", 32'(o_d[1]),   32'd0);
    chk("flush_out_f1h",  32'(o_f1h[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
